ps_swallow_ctrl: RTL and testbench
==================================

Name: ps_swallow_ctrl

Overview:
- Parametrised, fully synchronous pulse-swallow controller for the dual-modulus prescaler path.
- Counts prescaler output cycles (Fin) in frames of P cycles.
- Drives modulus control (mc) high for the first S cycles of each frame, so the total division is P*N + S.
- Successor to the fixed 3-bit swallow counter. Adds:
  - independent P/S widths;
  - frame-boundary shadow loading, so a sigma-delta modulator can update P/S glitch-free;
  - S>P clamping with an error flag;
  - enable;
  - selectable pulse or ~50% duty output.

Parameters:
P_WIDTH  6  width of program count p_val; P range 1..2^P_WIDTH-1
S_WIDTH  4  width of swallow count s_val; S_WIDTH <= P_WIDTH (elaboration error otherwise)

Ports:
Fin       input   1        prescaler output clock; all state on rising edge
rst       input   1        asynchronous reset, active-high
en        input   1        run enable, sampled on Fin
p_val     input   P_WIDTH  program count P for next frame
s_val     input   S_WIDTH  swallow count S for next frame
out_mode  input   1        0 = pulse output, 1 = duty output; latched per frame
mc        output  1        modulus control, 1 = prescaler divides by N+1
div_out   output  1        divided output
frame_st  output  1        high during cycle k=0 of each frame
s_clamp   output  1        high for the whole frame whose S was clamped to P

Behaviour:
- rst=1 (async): p_cnt=0, s_cnt=0, all shadows=0, running=0, mc=0, div_out=0, frame_st=0, s_clamp=0. Effective immediately, mid-frame included.
- All outputs are registered and change only on a Fin rising edge (or on reset). No combinational path from inputs to outputs.
- Frame cycle index k=0..Pe-1 is the Fin period following the k-th edge of the frame. The down-counter p_cnt holds Pe-1-k.
- Frame start edge: occurs when en=1 and (running=0 or p_cnt==0). At this edge:
  - Pe = max(p_val,1). p_val=0 is treated as 1.
  - Se = min(zero-extended s_val, Pe). s_clamp = (s_val > Pe).
  - Latch out_mode into mode_sh.
  - p_cnt = Pe-1; running=1.
- Other edges with en=1: p_cnt decrements. s_cnt decrements while nonzero. Shadows hold.
- Outputs in cycle k:
  - mc = (k < Se).
  - frame_st = (k==0).
  - div_out = (k==0) when mode_sh=0. div_out = (k < ceil(Pe/2)) when mode_sh=1.
- Input changes mid-frame are ignored until the next frame start. Inputs are sampled only at the frame start edge.
- Boundary cases:
  - Se=0: mc stays 0 for the whole frame.
  - Se=Pe: mc stays 1 for the whole frame.
  - Pe=1: every edge is a frame start. frame_st=1 and div_out=1 continuously. mc=(Se==1).
  - Pe=1 in duty mode: div_out=1 continuously.
  - Pe=2, duty mode: div_out = 1,0.
- en=0 sampled at an edge:
  - Abort: running=0, counters cleared, mc=0, div_out=0, frame_st=0. s_clamp holds its value.
  - When en returns to 1, the next edge is a fresh frame start with k=0.
- Wrap-around: the last frame cycle (p_cnt==0) is followed directly by k=0 of the next frame. No dead cycle, no gap in mc/div_out sequencing.

Decomposition:
- Shared package ps_div_pkg:
  - OUT_PULSE=1'b0 and OUT_DUTY=1'b1;
  - a function computing ceil(P/2) for a P_WIDTH operand;
  - the S_WIDTH<=P_WIDTH check macro.
- Sub-module swallow_down_counter (parametrised WIDTH):
  - ports: Fin, rst, load, load_val, en;
  - outputs: cnt, zero;
  - async-reset down-counter that saturates at 0;
  - instantiated twice, for p_cnt and s_cnt.
- The top level holds the shadow registers, clamp logic and output decode.

Test Plan:
- P=5, S=2, out_mode=0, en=1 after reset -> mc per cycle 1,1,0,0,0 repeating; div_out 1,0,0,0,0; frame_st equal to div_out; s_clamp=0.
- P=5, S=2, out_mode=1 -> div_out 1,1,1,0,0; mc unchanged from the pulse-mode case.
- p_val changes 5->7 and s_val 2->3 at cycle k=2 -> current frame finishes with 5 cycles. Next frame mc=1,1,1,0,0,0,0; div_out high at k=0 only.
- p_val=4, s_val=9 (S_WIDTH=4) -> mc=1 for all 4 cycles; s_clamp=1 for that frame. Setting s_val=1 -> s_clamp returns to 0 at the next frame start.
- p_val=0, s_val=3 -> Pe=1, Se=1; mc, div_out and frame_st constantly 1; s_clamp=1.
- rst pulsed asynchronously at k=3 of a P=6 frame -> all outputs 0 immediately. After release with en=1, the first edge gives k=0 (frame_st=1). en=0 at k=2 -> outputs 0 at the next edge; en=1 -> a new frame starts at k=0.

Source files
------------

// File: rtl/ps_div_pkg.sv
// ps_div_pkg: definitions shared by the pulse-swallow controller.
//   OUT_PULSE / OUT_DUTY : div_out shape, selected per frame by out_mode
//   ceil_half()          : ceil(P/2), the length of the high half in duty mode
//   PS_DIV_CHECK_WIDTHS  : elaboration-time check that S_WIDTH <= P_WIDTH
package ps_div_pkg;

  localparam logic OUT_PULSE = 1'b0;
  localparam logic OUT_DUTY  = 1'b1;

  // The operand is a zero-extended P_WIDTH value; callers cast the result back.
  function automatic logic [31:0] ceil_half(input logic [31:0] p);
    return (p >> 1) + {31'b0, p[0]};
  endfunction

endpackage

// A swallow count wider than the program count could never be honoured,
// so such a configuration is rejected at elaboration.
`ifndef PS_DIV_CHECK_WIDTHS
`define PS_DIV_CHECK_WIDTHS(PW, SW) \
  generate \
    if ((SW) > (PW)) begin : g_bad_width \
      $error("S_WIDTH must not exceed P_WIDTH"); \
    end \
  endgenerate
`endif

// File: rtl/swallow_down_counter.sv
// swallow_down_counter: down-counter that saturates at zero.
//   Fin      : clock, rising edge
//   rst      : asynchronous reset, active-high (count -> 0)
//   load     : load load_val this edge (has priority over counting)
//   load_val : value to load
//   en       : decrement enable when not loading
//   cnt      : current count
//   zero     : high when cnt == 0
module swallow_down_counter #(
  parameter int WIDTH = 6
) (
  input  logic             Fin,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic [WIDTH-1:0] cnt,
  output logic             zero
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge Fin or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - WIDTH'(1);
    end
  end

  assign cnt  = r_cnt;
  assign zero = (r_cnt == '0);

endmodule

// File: rtl/ps_swallow_ctrl.sv
// ps_swallow_ctrl: pulse-swallow controller for a dual-modulus prescaler.
// Counts Fin cycles in frames of Pe cycles and holds mc high for the first
// Se cycles, giving a total division of P*N + S. P, S and out_mode are
// captured only at a frame start, so they may change at any time.
//   Fin      : prescaler output clock, rising edge
//   rst      : asynchronous reset, active-high
//   en       : run enable; low aborts the current frame
//   p_val    : program count P (0 is treated as 1)
//   s_val    : swallow count S (clamped to Pe)
//   out_mode : 0 = pulse div_out, 1 = ~50% duty div_out
//   mc       : modulus control, 1 = divide by N+1
//   div_out  : divided output
//   frame_st : high in the first cycle of each frame
//   s_clamp  : high for a frame whose S exceeded Pe
module ps_swallow_ctrl
  import ps_div_pkg::*;
#(
  parameter int P_WIDTH = 6,
  parameter int S_WIDTH = 4
) (
  input  logic               Fin,
  input  logic               rst,
  input  logic               en,
  input  logic [P_WIDTH-1:0] p_val,
  input  logic [S_WIDTH-1:0] s_val,
  input  logic               out_mode,
  output logic               mc,
  output logic               div_out,
  output logic               frame_st,
  output logic               s_clamp
);

  `PS_DIV_CHECK_WIDTHS(P_WIDTH, S_WIDTH)

  logic               r_running;
  logic               r_mode_sh;
  logic [P_WIDTH-1:0] r_thr_sh;
  logic               r_mc;
  logic               r_div;
  logic               r_frame_st;
  logic               r_s_clamp;

  logic [P_WIDTH-1:0] w_p_eff;
  logic [P_WIDTH-1:0] w_s_ext;
  logic [P_WIDTH-1:0] w_s_eff;
  logic               w_s_over;
  logic [P_WIDTH-1:0] w_thr;
  logic               w_start;
  logic               w_load;
  logic [P_WIDTH-1:0] w_p_load_val;
  logic [P_WIDTH-1:0] w_s_load_val;
  logic [P_WIDTH-1:0] w_p_cnt;
  logic               w_p_zero;
  logic [P_WIDTH-1:0] w_p_next;
  logic [P_WIDTH-1:0] w_s_cnt_unused;
  logic               w_s_zero;

  // Effective frame parameters computed from the live inputs; they only
  // matter on the frame-start edge where they are captured.
  assign w_p_eff  = (p_val == '0) ? P_WIDTH'(1) : p_val;
  assign w_s_ext  = P_WIDTH'(s_val);
  assign w_s_over = (w_s_ext > w_p_eff);
  assign w_s_eff  = w_s_over ? w_p_eff : w_s_ext;

  // Duty mode is high for k < ceil(Pe/2). With p_cnt = Pe-1-k this is
  // p_cnt >= Pe - ceil(Pe/2), so only that threshold needs a shadow.
  assign w_thr = w_p_eff - P_WIDTH'(ceil_half(32'(w_p_eff)));

  // A frame starts when idle or after its last cycle; this is what removes
  // any dead cycle between frames, and makes Pe=1 start on every edge.
  assign w_start = en && (!r_running || w_p_zero);

  // Both counters load on a frame start and are cleared on an abort.
  assign w_load       = w_start || !en;
  assign w_p_load_val = en ? (w_p_eff - P_WIDTH'(1)) : '0;
  // s_cnt counts the mc-high cycles still to come after the current one.
  assign w_s_load_val = (en && (w_s_eff != '0)) ? (w_s_eff - P_WIDTH'(1)) : '0;

  assign w_p_next = w_p_cnt - P_WIDTH'(1);

  swallow_down_counter #(.WIDTH(P_WIDTH)) u_p_cnt (
    .Fin      (Fin),
    .rst      (rst),
    .load     (w_load),
    .load_val (w_p_load_val),
    .en       (en),
    .cnt      (w_p_cnt),
    .zero     (w_p_zero)
  );

  swallow_down_counter #(.WIDTH(P_WIDTH)) u_s_cnt (
    .Fin      (Fin),
    .rst      (rst),
    .load     (w_load),
    .load_val (w_s_load_val),
    .en       (en),
    .cnt      (w_s_cnt_unused),
    .zero     (w_s_zero)
  );

  // Outputs are registered with the value for the cycle that follows the edge.
  always_ff @(posedge Fin or posedge rst) begin
    if (rst) begin
      r_running  <= 1'b0;
      r_mode_sh  <= OUT_PULSE;
      r_thr_sh   <= '0;
      r_mc       <= 1'b0;
      r_div      <= 1'b0;
      r_frame_st <= 1'b0;
      r_s_clamp  <= 1'b0;
    end else if (!en) begin
      // Abort: s_clamp deliberately keeps reporting the last frame.
      r_running  <= 1'b0;
      r_mc       <= 1'b0;
      r_div      <= 1'b0;
      r_frame_st <= 1'b0;
    end else if (w_start) begin
      r_running  <= 1'b1;
      r_mode_sh  <= out_mode;
      r_thr_sh   <= w_thr;
      r_s_clamp  <= w_s_over;
      r_mc       <= (w_s_eff != '0);
      r_frame_st <= 1'b1;
      // k=0 is high in both modes since ceil(Pe/2) >= 1.
      r_div      <= 1'b1;
    end else begin
      r_mc       <= !w_s_zero;
      r_frame_st <= 1'b0;
      r_div      <= (r_mode_sh == OUT_DUTY) && (w_p_next >= r_thr_sh);
    end
  end

  assign mc       = r_mc;
  assign div_out  = r_div;
  assign frame_st = r_frame_st;
  assign s_clamp  = r_s_clamp;

endmodule

// File: tb/tb_ps_swallow_ctrl.sv
// Bench for ps_swallow_ctrl: a frame-level reference model pushes the
// expected {mc, div_out, frame_st, s_clamp} per Fin edge into a queue and a
// monitor pops and compares after each edge.
module tb_ps_swallow_ctrl;

  localparam int P_WIDTH = 6;
  localparam int S_WIDTH = 4;

  logic               Fin;
  logic               rst;
  logic               en;
  logic [P_WIDTH-1:0] p_val;
  logic [S_WIDTH-1:0] s_val;
  logic               out_mode;
  logic               mc;
  logic               div_out;
  logic               frame_st;
  logic               s_clamp;

  int n_checks = 0;
  int n_pass   = 0;

  logic [3:0] exp_q[$];

  // Reference model state: frame parameters and cycle index within the frame.
  int m_pe      = 1;
  int m_se      = 0;
  int m_k       = 0;
  bit m_mode    = 1'b0;
  bit m_running = 1'b0;
  bit m_clamp   = 1'b0;

  ps_swallow_ctrl #(.P_WIDTH(P_WIDTH), .S_WIDTH(S_WIDTH)) dut (
    .Fin      (Fin),
    .rst      (rst),
    .en       (en),
    .p_val    (p_val),
    .s_val    (s_val),
    .out_mode (out_mode),
    .mc       (mc),
    .div_out  (div_out),
    .frame_st (frame_st),
    .s_clamp  (s_clamp)
  );

  // ---------------- clock ----------------
  initial begin
    Fin = 1'b0;
    forever #5 Fin = ~Fin;
  end

  initial begin
    #200000;
    $display("FAIL timeout: run did not finish, got time %0t required < 200000", $time);
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  always @(posedge rst) begin
    m_running = 1'b0;
    m_clamp   = 1'b0;
    m_k       = 0;
  end

  always @(posedge Fin) begin
    logic [3:0] e;
    if (rst) begin
      m_running = 1'b0;
      m_clamp   = 1'b0;
      e = 4'b0000;
    end else if (!en) begin
      m_running = 1'b0;
      e = {3'b000, m_clamp};
    end else begin
      if (!m_running || m_k == m_pe - 1) begin
        m_pe      = (int'(p_val) == 0) ? 1 : int'(p_val);
        m_clamp   = int'(s_val) > m_pe;
        m_se      = m_clamp ? m_pe : int'(s_val);
        m_mode    = out_mode;
        m_k       = 0;
        m_running = 1'b1;
      end else begin
        m_k = m_k + 1;
      end
      e[3] = (m_k < m_se);
      e[2] = m_mode ? (m_k < (m_pe + 1) / 2) : (m_k == 0);
      e[1] = (m_k == 0);
      e[0] = m_clamp;
    end
    exp_q.push_back(e);
  end

  // ---------------- monitor / scoreboard ----------------
  always @(posedge Fin) begin
    logic [3:0] got;
    logic [3:0] want;
    #2;
    got = {mc, div_out, frame_st, s_clamp};
    n_checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL scoreboard_empty at %0t: got %b, no expectation queued", $time, got);
    end else begin
      want = exp_q.pop_front();
      if (got === want) n_pass++;
      else $display("FAIL cycle_out at %0t (k=%0d Pe=%0d Se=%0d): got {mc,div,fs,clamp}=%b required %b",
                    $time, m_k, m_pe, m_se, got, want);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge Fin);
  endtask

  task automatic set_frame(input int p, input int s, input bit mode);
    p_val    = P_WIDTH'(p);
    s_val    = S_WIDTH'(s);
    out_mode = mode;
  endtask

  // Waits on negedges until the model sits in cycle k of a running frame.
  task automatic wait_k(input int k);
    int budget;
    budget = 200;
    @(negedge Fin);
    while (!(m_running && m_k == k) && budget > 0) begin
      @(negedge Fin);
      budget--;
    end
    n_checks++;
    if (budget > 0) n_pass++;
    else $display("FAIL wait_k: got no cycle k=%0d within budget, required reaching it", k);
  endtask

  // Asserts rst between edges and checks the outputs clear without a clock edge.
  task automatic pulse_reset();
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({mc, div_out, frame_st, s_clamp} === 4'b0000) n_pass++;
    else $display("FAIL async_reset: got %b required 0000", {mc, div_out, frame_st, s_clamp});
    @(negedge Fin);
    rst = 1'b0;
  endtask

  task automatic drive_random(input int n);
    for (int i = 0; i < n; i++) begin
      int r;
      @(negedge Fin);
      r = $urandom_range(0, 99);
      en = (r >= 6);
      if ($urandom_range(0, 99) < 25) begin
        if ($urandom_range(0, 3) == 0) p_val = P_WIDTH'($urandom_range(0, (1 << P_WIDTH) - 1));
        else p_val = P_WIDTH'($urandom_range(0, 12));
        s_val    = S_WIDTH'($urandom_range(0, (1 << S_WIDTH) - 1));
        out_mode = 1'($urandom_range(0, 1));
      end
      if (r == 0) pulse_reset();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    en  = 1'b0;
    set_frame(5, 2, 1'b0);
    #1;
    n_checks++;
    if ({mc, div_out, frame_st, s_clamp} === 4'b0000) n_pass++;
    else $display("FAIL reset_state: got %b required 0000", {mc, div_out, frame_st, s_clamp});
    cycles(2);
    rst = 1'b0;
    en  = 1'b1;

    // P=5 S=2 pulse, then duty
    cycles(15);
    out_mode = 1'b1;
    cycles(12);
    out_mode = 1'b0;
    // mid-frame parameter change at k=2
    wait_k(2);
    set_frame(7, 3, 1'b0);
    cycles(20);
    // S clamped to P, then cleared
    set_frame(4, 9, 1'b0);
    cycles(10);
    s_val = 4'd1;
    cycles(10);
    // p_val=0 -> Pe=1, with clamp
    set_frame(0, 3, 1'b1);
    cycles(6);
    set_frame(1, 0, 1'b0);
    cycles(4);
    // Pe=2 duty, Se=Pe
    set_frame(2, 2, 1'b1);
    cycles(8);
    // async reset mid-frame at k=3 of P=6
    set_frame(6, 2, 1'b0);
    wait_k(3);
    pulse_reset();
    cycles(8);
    // abort at k=2 and resume
    wait_k(2);
    en = 1'b0;
    cycles(3);
    en = 1'b1;
    cycles(10);
    // randomized traffic
    drive_random(500);
    en = 1'b1;
    cycles(5);

    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d expectations left, required 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
